// File: rtl/mdio_master_if.sv
// mdio_master_if: command/response handshake between a requester and the MDIO master.
interface mdio_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [4:0]  cmd_phy_addr;
    logic [4:0]  cmd_reg_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/mdio_master.sv
// mdio_master: IEEE 802.3 clause 22 MDIO management master issuing one read or write frame per command.
module mdio_master #(
    parameter int CLK_DIV     = 20,
    parameter bit PREAMBLE_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    mdio_master_if.slave  bus,
    output logic          mdc,
    input  logic          mdio_in,
    output logic          mdio_out,
    output logic          mdio_oen
);
    typedef enum logic [2:0] {IDLE, SHIFT, TA, DATA, DONE} state_t;

    localparam logic [6:0] N          = PREAMBLE_EN ? 7'd64 : 7'd32;
    localparam logic [6:0] LAST_SHIFT = N - 7'd19;
    localparam logic [6:0] LAST_TA    = N - 7'd17;
    localparam logic [6:0] LAST_BIT   = N - 7'd1;
    localparam logic [8:0] DIV_HI     = 9'(CLK_DIV);
    localparam logic [8:0] DIV_LAST   = 9'(2 * CLK_DIV - 1);

    state_t      state, state_nx;
    logic [8:0]  div_cnt;
    logic [6:0]  bit_cnt;
    logic [63:0] sh;
    logic        rd_op;
    logic [15:0] rdata;
    logic        err;
    logic        accept, active, bit_end, sample;
    logic [31:0] frame;

    assign accept  = bus.cmd_valid && bus.cmd_ready;
    assign active  = state == SHIFT || state == TA || state == DATA;
    assign bit_end = div_cnt == DIV_LAST;
    assign sample  = rd_op && div_cnt == DIV_HI;
    assign frame   = {2'b01, bus.cmd_write ? 2'b01 : 2'b10, bus.cmd_phy_addr,
                      bus.cmd_reg_addr, 2'b10, bus.cmd_wdata};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.cmd_valid ? SHIFT : IDLE;
            SHIFT:   state_nx = bit_end && bit_cnt == LAST_SHIFT ? TA : SHIFT;
            TA:      state_nx = bit_end && bit_cnt == LAST_TA ? DATA : TA;
            DATA:    state_nx = bit_end && bit_cnt == LAST_BIT ? DONE : DATA;
            default: state_nx = IDLE;
        endcase
    end

    // Frame is left-aligned in sh so the next bit to send is always sh[63].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            sh      <= '1;
            rd_op   <= 1'b0;
            rdata   <= '0;
            err     <= 1'b0;
        end else if (accept) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            sh      <= PREAMBLE_EN ? {32'hFFFF_FFFF, frame} : {frame, 32'hFFFF_FFFF};
            rd_op   <= !bus.cmd_write;
            rdata   <= '0;
            err     <= 1'b0;
        end else if (active) begin
            div_cnt <= bit_end ? 9'd0 : div_cnt + 9'd1;
            if (bit_end) begin
                bit_cnt <= bit_cnt + 7'd1;
                sh      <= {sh[62:0], 1'b1};
            end
            if (sample && state == TA && bit_cnt == LAST_TA) err <= mdio_in;
            if (sample && state == DATA) rdata <= {rdata[14:0], mdio_in};
        end
    end

    assign mdc           = active && div_cnt >= DIV_HI;
    assign mdio_oen      = !(active && (!rd_op || state == SHIFT));
    assign mdio_out      = mdio_oen ? 1'b1 : sh[63];
    assign bus.cmd_ready = state == IDLE;
    assign bus.busy      = state != IDLE;
    assign bus.rsp_valid = state == DONE;
    assign bus.rsp_rdata = rdata;
    assign bus.rsp_err   = err;
endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: scoreboard bench for mdio_master with a simple PHY model on the pad.
module tb_mdio_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mdio_master_if ifa();
    mdio_master_if ifb();

    logic mdc_a, out_a, oen_a, in_a;
    logic mdc_b, out_b, oen_b;

    mdio_master #(.CLK_DIV(2), .PREAMBLE_EN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa),
        .mdc(mdc_a), .mdio_in(in_a), .mdio_out(out_a), .mdio_oen(oen_a)
    );

    mdio_master #(.CLK_DIV(4), .PREAMBLE_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb),
        .mdc(mdc_b), .mdio_in(1'b1), .mdio_out(out_b), .mdio_oen(oen_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // PHY: answers reads with TA=1,0 then phy_data; otherwise the pad floats high.
    logic        phy_en = 1'b0;
    logic [15:0] phy_data = '0;
    logic [17:0] phy_resp;
    int          rise_a = 0;
    int          rise_b = 0;
    logic        mdc_aq = 1'b0;
    logic        mdc_bq = 1'b0;
    logic [63:0] cap_line = '0;
    logic [63:0] cap_oen = '0;

    assign phy_resp = {2'b10, phy_data};

    always_comb begin
        in_a = out_a;
        if (oen_a) in_a = (phy_en && rise_a >= 46 && rise_a < 64) ? phy_resp[63 - rise_a] : 1'b1;
    end

    always @(posedge clk) begin
        mdc_aq <= mdc_a;
        if (ifa.cmd_valid && ifa.cmd_ready) rise_a <= 0;
        else if (mdc_a && !mdc_aq) begin
            rise_a <= rise_a + 1;
            if (rise_a < 64) begin
                cap_line[63 - rise_a] <= in_a;
                cap_oen[63 - rise_a]  <= oen_a;
            end
        end
    end

    always @(posedge clk) begin
        mdc_bq <= mdc_b;
        if (ifb.cmd_valid && ifb.cmd_ready) rise_b <= 0;
        else if (mdc_b && !mdc_bq) rise_b <= rise_b + 1;
    end

    typedef struct {
        logic [15:0] rd;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t q[$];

    always @(negedge clk) begin
        if (ifa.rsp_valid) begin
            if (q.size() == 0) chk("unexpected_rsp", ifa.rsp_valid, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("rsp_rdata", ifa.rsp_rdata, e.rd);
                chk("rsp_err", ifa.rsp_err, e.err);
                chk("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    function automatic logic [63:0] frame(input logic [1:0] op, input logic [4:0] p, input logic [4:0] r,
                                          input logic [17:0] tail);
        return {32'hFFFF_FFFF, 2'b01, op, p, r, tail};
    endfunction

    int last_acc;

    task automatic send(input logic w, input logic [4:0] p, input logic [4:0] r, input logic [15:0] d,
                        input logic [15:0] erd, input logic eerr, output int waited);
        exp_t e;
        ifa.cmd_write    = w;
        ifa.cmd_phy_addr = p;
        ifa.cmd_reg_addr = r;
        ifa.cmd_wdata    = d;
        ifa.cmd_valid    = 1'b1;
        waited = 0;
        while (!ifa.cmd_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (!ifa.cmd_ready) chk("accept_timeout", ifa.cmd_ready, 1);
        else begin
            e.rd = erd;
            e.err = eerr;
            e.cyc = cyc + 257;
            q.push_back(e);
            last_acc = cyc;
        end
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!ifa.cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", ifa.cmd_ready, 1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_mdc"}, mdc_a, 0);
        chk({tag, "_oen"}, oen_a, 1);
        chk({tag, "_out"}, out_a, 1);
        chk({tag, "_ready"}, ifa.cmd_ready, 1);
        chk({tag, "_busy"}, ifa.busy, 0);
        chk({tag, "_rsp_valid"}, ifa.rsp_valid, 0);
        chk({tag, "_rdata"}, ifa.rsp_rdata, 0);
        chk({tag, "_err"}, ifa.rsp_err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w, a1, c0, n;
        ifa.cmd_valid = 0; ifa.cmd_write = 0; ifa.cmd_phy_addr = 0; ifa.cmd_reg_addr = 0; ifa.cmd_wdata = 0;
        ifb.cmd_valid = 0; ifb.cmd_write = 0; ifb.cmd_phy_addr = 0; ifb.cmd_reg_addr = 0; ifb.cmd_wdata = 0;
        repeat (3) @(negedge clk);
        chk_reset("rst");
        chk("rst_b_ready", ifb.cmd_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        send(1'b1, 5'h01, 5'h00, 16'h1140, 16'h0000, 1'b0, w);
        ifa.cmd_valid = 0;
        wait_idle();
        chk("wr_line", cap_line, frame(2'b01, 5'h01, 5'h00, {2'b10, 16'h1140}));
        chk("wr_oen", cap_oen, 64'h0);
        chk("wr_bits", rise_a, 64);

        phy_en = 1'b1;
        phy_data = 16'h796D;
        send(1'b0, 5'h01, 5'h02, 16'h0000, 16'h796D, 1'b0, w);
        ifa.cmd_valid = 0;
        wait_idle();
        chk("rd_line", cap_line, frame(2'b10, 5'h01, 5'h02, {2'b10, 16'h796D}));
        chk("rd_oen", cap_oen, 64'h3FFFF);

        phy_en = 1'b0;
        send(1'b0, 5'h05, 5'h1F, 16'h0000, 16'hFFFF, 1'b1, w);
        ifa.cmd_valid = 0;
        wait_idle();
        chk("nophy_line", cap_line, frame(2'b10, 5'h05, 5'h1F, 18'h3FFFF));
        chk("nophy_oen", cap_oen, 64'h3FFFF);

        phy_en = 1'b1;
        phy_data = 16'h1234;
        send(1'b1, 5'h1F, 5'h1F, 16'hA5A5, 16'h0000, 1'b0, w);
        a1 = last_acc;
        send(1'b0, 5'h0A, 5'h03, 16'hFFFF, 16'h1234, 1'b0, w);
        ifa.cmd_valid = 0;
        chk("b2b_spacing", last_acc - a1, 258);
        chk("b2b_line", cap_line, frame(2'b01, 5'h1F, 5'h1F, {2'b10, 16'hA5A5}));
        wait_idle();
        chk("b2b_rd_line", cap_line, frame(2'b10, 5'h0A, 5'h03, {2'b10, 16'h1234}));

        @(negedge clk);
        ifb.cmd_write = 1'b1; ifb.cmd_phy_addr = 5'h03; ifb.cmd_reg_addr = 5'h04; ifb.cmd_wdata = 16'hBEEF;
        ifb.cmd_valid = 1'b1;
        chk("b_ready", ifb.cmd_ready, 1);
        c0 = cyc;
        @(negedge clk);
        ifb.cmd_valid = 1'b0;
        n = 0;
        while (!ifb.rsp_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("b_latency", cyc - c0, 257);
        chk("b_bits", rise_b, 32);
        chk("b_rdata", ifb.rsp_rdata, 0);
        chk("b_err", ifb.rsp_err, 0);

        phy_data = 16'hC3C3;
        send(1'b0, 5'h02, 5'h01, 16'h0000, 16'hC3C3, 1'b0, w);
        ifa.cmd_valid = 0;
        n = 0;
        while (rise_a < 50 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("abort_in_data", rise_a >= 50, 1);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk_reset("abort");
        phy_en = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send(1'b1, 5'h11, 5'h12, 16'h0F0F, 16'h0000, 1'b0, w);
        ifa.cmd_valid = 0;
        chk("post_rst_accept_wait", w, 0);
        wait_idle();
        chk("post_rst_line", cap_line, frame(2'b01, 5'h11, 5'h12, {2'b10, 16'h0F0F}));

        repeat (5) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mdio_master.md
MDIO_MASTER -- requirements
Module: mdio_master

Interface
REQ-001 Parameter CLK_DIV, default 20: MDC half-period in clk cycles; legal range 2..255; 20 gives 1.25 MHz MDC from 50 MHz.
REQ-002 Parameter PREAMBLE_EN, default 1: 1 sends a 32-bit all-ones preamble; 0 suppresses it.
REQ-003 clk  in  1  system clock; the single clock of the block.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  block is idle and accepts a command.
REQ-007 cmd_write  in  1  1 = write (OP 01), 0 = read (OP 10).
REQ-008 cmd_phy_addr  in  5  PHYAD field.
REQ-009 cmd_reg_addr  in  5  REGAD field.
REQ-010 cmd_wdata  in  16  write data.
REQ-011 rsp_valid  out  1  one-cycle pulse at transaction end.
REQ-012 rsp_rdata  out  16  read data, or 0 for writes; valid with rsp_valid.
REQ-013 rsp_err  out  1  read not acknowledged by the PHY; valid with rsp_valid.
REQ-014 busy  out  1  transaction in progress.
REQ-015 mdc  out  1  management clock to the PHY.
REQ-016 mdio_in  in  1  MDIO pad input.
REQ-017 mdio_out  out  1  MDIO pad output value.
REQ-018 mdio_oen  out  1  output enable, active-high tristate: 1 = pad released, 0 = drive mdio_out.

Function
REQ-019 A command shall be accepted in the cycle where cmd_valid and cmd_ready are both 1, and all cmd_* fields shall be latched in that cycle.
REQ-020 cmd_ready shall be 1 only in state IDLE, and busy shall equal the inverse of cmd_ready.
REQ-021 States shall be IDLE -> SHIFT -> TA -> DATA -> DONE -> IDLE.
  - SHIFT: preamble if enabled, ST=01, OP, PHYAD, REGAD, MSB first.
  - TA: 2 bits.
  - DATA: 16 bits, MSB first.
  - DONE: 1 cycle.
REQ-022 Frame length N shall be 64 bits with preamble and 32 bits without it.
REQ-023 Each bit shall occupy 2*CLK_DIV clk cycles: CLK_DIV cycles with mdc=0, then CLK_DIV cycles with mdc=1; the first bit shall start in the cycle after acceptance.
REQ-024 mdio_out and mdio_oen shall change only in the first cycle of a bit's low phase, which is the MDC falling edge or frame start.
REQ-025 mdio_in shall be sampled in the clk cycle in which mdc goes 0->1.
REQ-026 Write: mdio_oen shall be 0 for all N bits; TA shall drive 1 then 0; DATA shall drive cmd_wdata.
REQ-027 Read: mdio_oen shall be 0 through REGAD, and 1 for TA and DATA.
  - The second TA bit sample equal to 1 shall set rsp_err=1.
  - The 16 DATA samples shall form rsp_rdata regardless of rsp_err.
REQ-028 rsp_valid shall pulse in DONE, exactly N*2*CLK_DIV+1 cycles after the accept cycle; cmd_ready shall be 1 in the following cycle.
REQ-029 A back-to-back command shall be accepted at the earliest in the cycle after DONE.
REQ-030 In IDLE: mdc=0, mdio_oen=1, mdio_out=1, and mdc shall not toggle.
REQ-031 cmd_valid while busy shall be ignored without being queued.
REQ-032 cmd_* field changes after acceptance shall have no effect on the frame in progress.
REQ-033 The bit counter and divider counter shall be wide enough for 64 bits and CLK_DIV=255 without wrap.

Reset
REQ-034 On rst_n=0 the block shall immediately take these values, independent of clk:
  - state=IDLE;
  - mdc=0, mdio_oen=1, mdio_out=1;
  - cmd_ready=1, busy=0;
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-035 Reset asserted mid-transaction shall abort the frame with no rsp_valid, and the MDIO pad shall be released at once.
REQ-036 After rst_n deasserts, the first command shall be accepted on the first clk edge with cmd_valid=1.

Verification
REQ-037 Write, CLK_DIV=2, PREAMBLE_EN=1, PHY=0x01, REG=0x00, data=0x1140:
  - MDIO bitstream shall be 32x'1', 01 01 00001 00000 10 0001000101000000, with mdio_oen=0 throughout.
  - rsp_valid shall pulse at cycle 257 after accept, with rsp_rdata=0 and rsp_err=0.
REQ-038 Read, PHY model drives TA bit 2=0 and data 0x796D:
  - mdio_oen shall be 1 from bit 46 onward.
  - Response shall be rsp_rdata=0x796D, rsp_err=0.
REQ-039 Read with no PHY (pad pulled high): response shall be rsp_err=1, rsp_rdata=0xFFFF.
REQ-040 PREAMBLE_EN=0, CLK_DIV=4: frame shall be 32 bits, and rsp_valid shall pulse at cycle 257 after accept.
REQ-041 cmd_valid held high across two commands: accepts shall be separated by N*2*CLK_DIV+2 cycles, and a command presented mid-frame shall have no effect.
REQ-042 rst_n pulsed low during DATA of a read:
  - Outputs shall take the REQ-034 values immediately, with no rsp_valid.
  - A subsequent write shall complete normally.
